adc_meas_sampler: RTL and testbench

ADC_MEAS_SAMPLER -- requirements
Module: adc_meas_sampler

---
 rtl/adc_meas_pkg.sv | 33 +++
 rtl/adc_meas_sampler_if.sv | 26 ++
 rtl/adc_spi_frame.sv | 81 ++++++++
 rtl/adc_meas_sampler.sv | 190 +++++++++++++++++++
 tb/tb_adc_meas_sampler.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_meas_pkg.sv
// rtl/adc_meas_pkg.sv - shared types, frame geometry and DIN helper for the ADC sampler
package adc_meas_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        GAP,
        UPDATE
    } state_t;

    localparam int FRAME_BITS     = 16;
    localparam int ADDR_FIRST_BIT = 2;
    localparam int DATA_FIRST_BIT = 4;
    localparam int DATA_BITS      = 8;
    localparam int NUM_CH         = 4;

    // Value of ADC_DIN during frame bit bit_idx: the 3-bit address MSB first
    // on bits ADDR_FIRST_BIT..ADDR_FIRST_BIT+2, zero everywhere else.
    function automatic logic din_bit(input logic [3:0] bit_idx, input logic [2:0] addr);
        logic b;
        b = 1'b0;
        if (bit_idx == 4'(ADDR_FIRST_BIT)) begin
            b = addr[2];
        end else if (bit_idx == 4'(ADDR_FIRST_BIT + 1)) begin
            b = addr[1];
        end else if (bit_idx == 4'(ADDR_FIRST_BIT + 2)) begin
            b = addr[0];
        end
        return b;
    endfunction

endpackage

// File: rtl/adc_meas_sampler_if.sv
// rtl/adc_meas_sampler_if.sv - serial ADC pin bundle
// Signals:
//   ADC_CS_N  chip select, active low (master drives)
//   ADC_SCLK  serial clock, idles high (master drives)
//   ADC_DIN   address line into the ADC (master drives)
//   ADC_DOUT  conversion data out of the ADC (slave drives)
interface adc_meas_sampler_if;
    logic ADC_CS_N;
    logic ADC_SCLK;
    logic ADC_DIN;
    logic ADC_DOUT;

    modport master (
        output ADC_CS_N,
        output ADC_SCLK,
        output ADC_DIN,
        input  ADC_DOUT
    );

    modport slave (
        input  ADC_CS_N,
        input  ADC_SCLK,
        input  ADC_DIN,
        output ADC_DOUT
    );
endinterface

// File: rtl/adc_spi_frame.sv
// rtl/adc_spi_frame.sv - generates one 16-bit SCLK frame, shifts out address, captures 8 data bits
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   start      one-cycle request; the first SCLK low half begins on the next cycle
//   addr       channel address sent MSB first on bits 2..4
//   sdo        ADC serial data, sampled on SCLK rising edges of bits 4..11
//   done       high in the last cycle of the final SCLK high half
//   data       captured 8-bit result, MSB first
//   sclk, din  serial clock (idles high) and address line
module adc_spi_frame
    import adc_meas_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           addr,
    input  logic                 sdo,
    output logic                 done,
    output logic [DATA_BITS-1:0] data,
    output logic                 sclk,
    output logic                 din
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0] LAST_BIT   = 4'(FRAME_BITS - 1);
    localparam logic [3:0] DATA_FIRST = 4'(DATA_FIRST_BIT);
    localparam logic [3:0] DATA_LAST  = 4'(DATA_FIRST_BIT + DATA_BITS - 1);

    logic             active;
    logic [DIV_W-1:0] half_cnt;
    logic [3:0]       bit_idx;
    logic [2:0]       addr_q;
    logic             in_data;

    assign in_data = (bit_idx >= DATA_FIRST) && (bit_idx <= DATA_LAST);
    assign done    = active && sclk && (half_cnt == HALF_LAST) && (bit_idx == LAST_BIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= 1'b0;
            half_cnt <= '0;
            bit_idx  <= '0;
            addr_q   <= '0;
            data     <= '0;
            sclk     <= 1'b1;
            din      <= 1'b0;
        end else if (start) begin
            // Falling edge of bit 0 happens right here.
            active   <= 1'b1;
            half_cnt <= '0;
            bit_idx  <= '0;
            addr_q   <= addr;
            sclk     <= 1'b0;
            din      <= din_bit(4'd0, addr);
        end else if (active) begin
            if (half_cnt == HALF_LAST) begin
                half_cnt <= '0;
                if (!sclk) begin
                    sclk <= 1'b1;
                    if (in_data) begin
                        data <= {data[DATA_BITS-2:0], sdo};
                    end
                end else if (bit_idx == LAST_BIT) begin
                    // Frame finished: SCLK simply stays high.
                    active <= 1'b0;
                    din    <= 1'b0;
                end else begin
                    sclk    <= 1'b0;
                    bit_idx <= bit_idx + 4'd1;
                    din     <= din_bit(bit_idx + 4'd1, addr_q);
                end
            end else begin
                half_cnt <= half_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/adc_meas_sampler.sv
// rtl/adc_meas_sampler.sv - periodic 4-channel serial ADC sweep with per-channel averaging
// Ports:
//   CLOCK_50         single clock, rising edge
//   RST              asynchronous active-high reset
//   adc              ADC pins (CS_N, SCLK, DIN out; DOUT in)
//   VinH..TempL      high/low nibbles of the channel 0..3 averages
//   upd              one-cycle pulse when the nibble outputs change
//   busy             high while a sweep is in progress
module adc_meas_sampler
    import adc_meas_pkg::*;
#(
    parameter int CLK_DIV        = 25,
    parameter int REFRESH_CYCLES = 5_000_000,
    parameter int AVG_LOG2       = 2
) (
    input  logic                       CLOCK_50,
    input  logic                       RST,
    adc_meas_sampler_if.master         adc,
    output logic [3:0]                 VinH,
    output logic [3:0]                 VinL,
    output logic [3:0]                 VoutH,
    output logic [3:0]                 VoutL,
    output logic [3:0]                 IoutH,
    output logic [3:0]                 IoutL,
    output logic [3:0]                 TempH,
    output logic [3:0]                 TempL,
    output logic                       upd,
    output logic                       busy
);

    localparam int SAMPLES    = 1 << AVG_LOG2;
    localparam int NUM_FRAMES = NUM_CH * SAMPLES + 1;
    localparam int FRAME_W    = $clog2(NUM_FRAMES + 1);
    localparam int DIV_W      = $clog2(2 * CLK_DIV + 1);
    localparam int REF_W      = $clog2(REFRESH_CYCLES + 1);
    localparam int ACC_W      = DATA_BITS + AVG_LOG2;

    localparam logic [DIV_W-1:0]   SETUP_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]   GAP_LAST    = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [FRAME_W-1:0] LAST_FRAME  = FRAME_W'(NUM_FRAMES - 1);
    localparam logic [FRAME_W-1:0] ADDR_FRAMES = FRAME_W'(NUM_CH * SAMPLES);
    localparam logic [REF_W-1:0]   REF_LAST    = REF_W'(REFRESH_CYCLES - 1);

    state_t               state;
    logic                 cs_n;
    logic [DIV_W-1:0]     div_cnt;
    logic [FRAME_W-1:0]   frame_idx;
    logic [FRAME_W-1:0]   prev_frame;
    logic [2:0]           frame_addr;
    logic [1:0]           prev_ch;
    logic [REF_W-1:0]     ref_cnt;
    logic                 wrap;
    logic                 frame_start;
    logic                 frame_done;
    logic [DATA_BITS-1:0] frame_data;
    logic                 sclk;
    logic                 din;
    logic [ACC_W-1:0]     acc  [NUM_CH];
    logic [DATA_BITS-1:0] hold [NUM_CH];

    // Free-running refresh timer; its wrap only matters while IDLE.
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            ref_cnt <= '0;
        end else if (ref_cnt == REF_LAST) begin
            ref_cnt <= '0;
        end else begin
            ref_cnt <= ref_cnt + REF_W'(1);
        end
    end

    assign wrap = (ref_cnt == REF_LAST);

    // Channel-major address order, with a trailing dummy frame to address 0
    // whose only purpose is to clock out the previous conversion.
    assign prev_frame = frame_idx - FRAME_W'(1);
    assign prev_ch    = 2'(prev_frame >> AVG_LOG2);
    always_comb begin
        frame_addr = 3'd0;
        if (frame_idx < ADDR_FRAMES) begin
            frame_addr = 3'(frame_idx >> AVG_LOG2);
        end
    end

    assign frame_start = (state == CS_SETUP) && (div_cnt == SETUP_LAST);

    adc_spi_frame #(
        .CLK_DIV (CLK_DIV)
    ) u_frame (
        .clk   (CLOCK_50),
        .rst   (RST),
        .start (frame_start),
        .addr  (frame_addr),
        .sdo   (adc.ADC_DOUT),
        .done  (frame_done),
        .data  (frame_data),
        .sclk  (sclk),
        .din   (din)
    );

    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cs_n      <= 1'b1;
            busy      <= 1'b0;
            upd       <= 1'b0;
            div_cnt   <= '0;
            frame_idx <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i]  <= '0;
                hold[i] <= '0;
            end
        end else begin
            upd <= 1'b0;
            case (state)
                IDLE: begin
                    if (wrap) begin
                        state     <= CS_SETUP;
                        cs_n      <= 1'b0;
                        busy      <= 1'b1;
                        div_cnt   <= '0;
                        frame_idx <= '0;
                        for (int i = 0; i < NUM_CH; i++) begin
                            acc[i] <= '0;
                        end
                    end
                end
                CS_SETUP: begin
                    if (div_cnt == SETUP_LAST) begin
                        state   <= SHIFT;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                SHIFT: begin
                    if (frame_done) begin
                        state   <= GAP;
                        cs_n    <= 1'b1;
                        div_cnt <= '0;
                        // Frame k returns the conversion requested in frame k-1;
                        // frame 0's result belongs to no request of this sweep.
                        if (frame_idx != '0) begin
                            acc[prev_ch] <= acc[prev_ch] + ACC_W'(frame_data);
                        end
                    end
                end
                GAP: begin
                    if (div_cnt == GAP_LAST) begin
                        div_cnt <= '0;
                        if (frame_idx == LAST_FRAME) begin
                            state <= UPDATE;
                            upd   <= 1'b1;
                            for (int i = 0; i < NUM_CH; i++) begin
                                hold[i] <= DATA_BITS'(acc[i] >> AVG_LOG2);
                            end
                        end else begin
                            state     <= CS_SETUP;
                            cs_n      <= 1'b0;
                            frame_idx <= frame_idx + FRAME_W'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                UPDATE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign adc.ADC_CS_N = cs_n;
    assign adc.ADC_SCLK = sclk;
    assign adc.ADC_DIN  = din;

    assign VinH  = hold[0][7:4];
    assign VinL  = hold[0][3:0];
    assign VoutH = hold[1][7:4];
    assign VoutL = hold[1][3:0];
    assign IoutH = hold[2][7:4];
    assign IoutL = hold[2][3:0];
    assign TempH = hold[3][7:4];
    assign TempL = hold[3][3:0];

endmodule

// File: tb/tb_adc_meas_sampler.sv
// tb/tb_adc_meas_sampler.sv - randomized self-checking bench with ADC slave and timing model
module tb_adc_meas_sampler;

    localparam int D         = 25;
    localparam int R         = 200;
    localparam int FRAME_CYC = 35 * D;
    localparam int NFR       = 17;
    localparam int SWEEP     = NFR * FRAME_CYC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] VinH, VinL, VoutH, VoutL, IoutH, IoutL, TempH, TempL;
    logic upd, busy;

    adc_meas_sampler_if adc_bus();

    adc_meas_sampler #(
        .CLK_DIV        (D),
        .REFRESH_CYCLES (R),
        .AVG_LOG2       (2)
    ) dut (
        .CLOCK_50 (clk),
        .RST      (rst),
        .adc      (adc_bus),
        .VinH     (VinH),
        .VinL     (VinL),
        .VoutH    (VoutH),
        .VoutL    (VoutL),
        .IoutH    (IoutH),
        .IoutL    (IoutL),
        .TempH    (TempH),
        .TempL    (TempL),
        .upd      (upd),
        .busy     (busy)
    );

    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ADC slave state
    int         adc_fi;
    int         bit_cnt;
    int         sweep_no = 0;
    int         occ [4];
    int         sum [4];
    logic [7:0] rnd [4][4];
    logic [7:0] resp;
    logic [2:0] rx_addr;
    logic [2:0] last_addr;
    logic       prev_cs, prev_sclk;
    logic       cs, sc, di;

    // Timing model state
    int         n;
    bit         msw;
    int         s;
    int         t, f, o, h, b;
    logic [2:0] av;
    logic [7:0] exp_hold [4];
    logic       e_cs, e_sc, e_di, e_upd;
    int         first_upd_n = -1;
    int         first_fall_n = -1;

    function automatic logic [7:0] pick(input int mode, input int ch, input int k);
        logic [7:0] v;
        v = rnd[ch][k];
        if (mode == 0) begin
            case (ch)
                0: v = 8'h3C;
                1: v = 8'h81;
                2: v = 8'hFF;
                default: v = 8'h00;
            endcase
        end else if (mode == 1 && ch == 0) begin
            v = 8'h10 + 8'(k);
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            adc_fi           = 0;
            bit_cnt          = 0;
            prev_cs          = 1'b1;
            prev_sclk        = 1'b1;
            rx_addr          = '0;
            last_addr        = '0;
            adc_bus.ADC_DOUT = 1'b0;
            n                = 0;
            msw              = 0;
            first_fall_n     = -1;
            for (int c = 0; c < 4; c++) begin
                occ[c]      = 0;
                sum[c]      = 0;
                exp_hold[c] = 8'h00;
            end
        end else begin
            // Timing model: sweep starts on every R-th cycle while idle, lasts SWEEP+1 cycles.
            n++;
            if (msw && (n - s) == SWEEP + 1) begin
                msw = 0;
            end else if (!msw && (n % R) == 0) begin
                msw = 1;
                s   = n;
            end

            // ADC slave reacting to the pins it sees.
            cs = adc_bus.ADC_CS_N;
            sc = adc_bus.ADC_SCLK;
            di = adc_bus.ADC_DIN;
            if (prev_cs && !cs) begin
                if (first_fall_n < 0) first_fall_n = n;
                if (adc_fi == 0) begin
                    for (int c = 0; c < 4; c++) begin
                        occ[c] = 0;
                        sum[c] = 0;
                        for (int k = 0; k < 4; k++) rnd[c][k] = 8'($urandom);
                    end
                    resp = 8'hA5;
                end else begin
                    resp = pick(sweep_no, int'(last_addr[1:0]), occ[last_addr[1:0]] % 4);
                    sum[last_addr[1:0]] += int'(resp);
                    occ[last_addr[1:0]]++;
                end
                adc_fi++;
                bit_cnt = -1;
                rx_addr = '0;
            end
            if (!cs && prev_sclk && !sc) begin
                bit_cnt++;
                adc_bus.ADC_DOUT = (bit_cnt >= 4 && bit_cnt <= 11) ? resp[11 - bit_cnt] : 1'b0;
            end
            if (!cs && !prev_sclk && sc && bit_cnt >= 2 && bit_cnt <= 4) begin
                rx_addr = {rx_addr[1:0], di};
            end
            if (!prev_cs && cs) begin
                last_addr = rx_addr;
            end
            prev_cs   = cs;
            prev_sclk = sc;

            // Expected pin values from the frame geometry.
            e_cs = 1'b1;
            e_sc = 1'b1;
            e_di = 1'b0;
            t    = msw ? (n - s) : 0;
            if (msw && t < SWEEP) begin
                f = t / FRAME_CYC;
                o = t % FRAME_CYC;
                if (o < 33 * D) begin
                    e_cs = 1'b0;
                    if (o >= D) begin
                        h    = (o - D) / D;
                        e_sc = (h % 2) == 1;
                        b    = h / 2;
                        av   = (f < 16) ? 3'(f / 4) : 3'd0;
                        if (b >= 2 && b <= 4) e_di = av[4 - b];
                    end
                end
            end
            e_upd = msw && (t == SWEEP);
            if (e_upd) begin
                for (int c = 0; c < 4; c++) exp_hold[c] = 8'(sum[c] / 4);
            end

            check("pins{cs,sclk,din,busy,upd}", {cs, sc, di, busy, upd}, {e_cs, e_sc, e_di, 1'(msw), e_upd});
            check("nibbles", {VinH, VinL, VoutH, VoutL, IoutH, IoutL, TempH, TempL},
                  {exp_hold[0], exp_hold[1], exp_hold[2], exp_hold[3]});

            if (upd) begin
                check("frames_per_sweep", adc_fi, NFR);
                if (first_upd_n < 0) first_upd_n = n;
                adc_fi = 0;
                sweep_no++;
            end
        end
    end

    task automatic wait_sweeps(input int target, input string name);
        int i;
        for (i = 0; i < 20000 && sweep_no < target; i++) begin
            @(negedge clk);
            #1;
        end
        if (sweep_no < target) begin
            checks++;
            failures++;
            $display("FAIL %s: timeout got %0d sweeps expected %0d", name, sweep_no, target);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;

        wait_sweeps(1, "sweep1_wait");
        check("first_upd_cycle", first_upd_n, 15075);
        check("VinH", VinH, 4'h3);
        check("VinL", VinL, 4'hC);
        check("VoutH", VoutH, 4'h8);
        check("VoutL", VoutL, 4'h1);
        check("IoutH", IoutH, 4'hF);
        check("IoutL", IoutL, 4'hF);
        check("TempH", TempH, 4'h0);
        check("TempL", TempL, 4'h0);

        wait_sweeps(2, "sweep2_wait");
        check("ch0_avg_truncated", {VinH, VinL}, 8'h11);

        wait_sweeps(3, "sweep3_wait");

        for (int i = 0; i < 20000 && adc_fi < 10; i++) begin
            @(negedge clk);
            #1;
        end
        check("reached_frame9", adc_fi, 10);
        repeat (100) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_cs_n", adc_bus.ADC_CS_N, 1'b1);
        check("rst_sclk", adc_bus.ADC_SCLK, 1'b1);
        check("rst_din", adc_bus.ADC_DIN, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_upd", upd, 1'b0);
        check("rst_nibbles", {VinH, VinL, VoutH, VoutL, IoutH, IoutL, TempH, TempL}, 32'h0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        repeat (R + 60) @(negedge clk);
        #1;
        check("restart_after_full_refresh", first_fall_n, R);
        check("no_upd_after_rst", sweep_no, 3);
        check("hold_zero_after_rst", {VinH, VinL, VoutH, VoutL, IoutH, IoutL, TempH, TempL}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
